// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared command codes, operand addresses and decoder state encoding
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_OP_A    = 3'd4,
    ST_OP_B    = 3'd5,
    ST_ALU_FN  = 3'd6
  } rx_state_t;

endpackage

// File: rtl/sys_ctrl_rx_decoder.sv
// rtl/sys_ctrl_rx_decoder.sv - UART RX byte-frame decoder driving register-file and ALU strobes
module sys_ctrl_rx_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter int          ADDR_WIDTH  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_EN,
  output logic                  CMD_ERR
);

  rx_state_t             state, state_n;
  logic [ADDR_WIDTH-1:0] addr_lat, addr_lat_n;
  logic [15:0]           tmo_cnt, tmo_cnt_n;
  logic [ADDR_WIDTH-1:0] address_n;
  logic [DATA_WIDTH-1:0] wr_data_n;
  logic [3:0]            alu_fun_n;
  logic                  wr_en_n, rd_en_n, alu_en_n, clk_en_n, cmd_err_n;
  logic                  tmo_hit;

  // Timeout only matters mid-frame; an arriving byte always takes priority over expiry.
  assign tmo_hit = (TIMEOUT_CYC != 16'd0) && (state != ST_IDLE) &&
                   (tmo_cnt == TIMEOUT_CYC - 16'd1);

  // Register state, address latch, timeout counter and all outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      addr_lat <= '0;
      tmo_cnt  <= '0;
      Address  <= '0;
      WrData   <= '0;
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      ALU_FUN  <= '0;
      ALU_EN   <= 1'b0;
      CLK_EN   <= 1'b0;
      CMD_ERR  <= 1'b0;
    end else begin
      state    <= state_n;
      addr_lat <= addr_lat_n;
      tmo_cnt  <= tmo_cnt_n;
      Address  <= address_n;
      WrData   <= wr_data_n;
      WrEn     <= wr_en_n;
      RdEn     <= rd_en_n;
      ALU_FUN  <= alu_fun_n;
      ALU_EN   <= alu_en_n;
      CLK_EN   <= clk_en_n;
      CMD_ERR  <= cmd_err_n;
    end
  end

  // Decode the incoming byte against the current frame position; strobes default low, data holds.
  always_comb begin
    state_n    = state;
    addr_lat_n = addr_lat;
    tmo_cnt_n  = '0;
    address_n  = Address;
    wr_data_n  = WrData;
    alu_fun_n  = ALU_FUN;
    wr_en_n    = 1'b0;
    rd_en_n    = 1'b0;
    alu_en_n   = 1'b0;
    cmd_err_n  = 1'b0;

    if (RX_D_VLD) begin
      case (state)
        ST_IDLE: begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_WR))           state_n = ST_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      state_n = ST_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_n = ST_OP_A;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_n = ST_ALU_FN;
          else                                            cmd_err_n = 1'b1;
        end
        ST_WR_ADDR: begin
          addr_lat_n = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n    = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          wr_en_n   = 1'b1;
          address_n = addr_lat;
          wr_data_n = RX_P_DATA;
          state_n   = ST_IDLE;
        end
        ST_RD_ADDR: begin
          rd_en_n   = 1'b1;
          address_n = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n   = ST_IDLE;
        end
        ST_OP_A: begin
          wr_en_n   = 1'b1;
          address_n = ADDR_WIDTH'(OPA_ADDR);
          wr_data_n = RX_P_DATA;
          state_n   = ST_OP_B;
        end
        ST_OP_B: begin
          wr_en_n   = 1'b1;
          address_n = ADDR_WIDTH'(OPB_ADDR);
          wr_data_n = RX_P_DATA;
          state_n   = ST_ALU_FN;
        end
        ST_ALU_FN: begin
          alu_en_n  = 1'b1;
          alu_fun_n = RX_P_DATA[3:0];
          state_n   = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_hit) begin
        cmd_err_n = 1'b1;
        state_n   = ST_IDLE;
      end else if (TIMEOUT_CYC != 16'd0) begin
        tmo_cnt_n = tmo_cnt + 16'd1;
      end
    end

    // Gate stays open for the whole ALU frame, including the launch cycle itself.
    clk_en_n = (state_n == ST_OP_A) || (state_n == ST_OP_B) ||
               (state_n == ST_ALU_FN) || alu_en_n;
  end

endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
// tb/tb_sys_ctrl_rx_decoder.sv - directed self-checking bench for sys_ctrl_rx_decoder
module tb_sys_ctrl_rx_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] ALU_FUN;
  logic       ALU_EN;
  logic       CLK_EN;
  logic       CMD_ERR;

  int checks = 0;
  int errors = 0;
  int cnt_err;
  int cnt_wr;

  sys_ctrl_rx_decoder #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .TIMEOUT_CYC(16'd20)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_P_DATA(RX_P_DATA),
    .RX_D_VLD (RX_D_VLD),
    .Address  (Address),
    .WrData   (WrData),
    .WrEn     (WrEn),
    .RdEn     (RdEn),
    .ALU_FUN  (ALU_FUN),
    .ALU_EN   (ALU_EN),
    .CLK_EN   (CLK_EN),
    .CMD_ERR  (CMD_ERR)
  );

  // 10 ns system clock.
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1 ns after an edge; leaves time 1 ns after the edge that sampled the byte.
  task automatic pulse(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},    32'(Address), 32'h0);
    chk({tag, "_wrdata"},  32'(WrData),  32'h0);
    chk({tag, "_wren"},    32'(WrEn),    32'h0);
    chk({tag, "_rden"},    32'(RdEn),    32'h0);
    chk({tag, "_alufun"},  32'(ALU_FUN), 32'h0);
    chk({tag, "_aluen"},   32'(ALU_EN),  32'h0);
    chk({tag, "_clken"},   32'(CLK_EN),  32'h0);
    chk({tag, "_cmderr"},  32'(CMD_ERR), 32'h0);
  endtask

  initial begin
    RST       = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    idle(3);
    chk_all_zero("reset");
    RST = 1'b0;
    idle(2);

    // Write frame with 16-cycle gaps
    pulse(8'hAA);
    chk("wr_cmd_no_wren", 32'(WrEn), 32'h0);
    idle(15);
    pulse(8'h05);
    chk("wr_addr_no_wren", 32'(WrEn), 32'h0);
    idle(15);
    pulse(8'h3C);
    chk("wr_wren",   32'(WrEn),    32'h1);
    chk("wr_addr",   32'(Address), 32'h5);
    chk("wr_data",   32'(WrData),  32'h3C);
    chk("wr_rden",   32'(RdEn),    32'h0);
    chk("wr_aluen",  32'(ALU_EN),  32'h0);
    idle(1);
    chk("wr_wren_one_cycle", 32'(WrEn), 32'h0);

    // Read frame, upper address bits dropped
    pulse(8'hBB);
    pulse(8'h27);
    chk("rd_rden", 32'(RdEn),    32'h1);
    chk("rd_addr", 32'(Address), 32'h7);
    chk("rd_wren", 32'(WrEn),    32'h0);
    idle(1);
    chk("rd_rden_one_cycle", 32'(RdEn), 32'h0);

    // ALU frame, back-to-back bytes
    pulse(8'hCC);
    chk("alu_cc_clken", 32'(CLK_EN), 32'h1);
    chk("alu_cc_wren",  32'(WrEn),   32'h0);
    pulse(8'h10);
    chk("alu_opa_wren",  32'(WrEn),    32'h1);
    chk("alu_opa_addr",  32'(Address), 32'h0);
    chk("alu_opa_data",  32'(WrData),  32'h10);
    chk("alu_opa_clken", 32'(CLK_EN),  32'h1);
    pulse(8'h20);
    chk("alu_opb_wren",  32'(WrEn),    32'h1);
    chk("alu_opb_addr",  32'(Address), 32'h1);
    chk("alu_opb_data",  32'(WrData),  32'h20);
    chk("alu_opb_clken", 32'(CLK_EN),  32'h1);
    pulse(8'h03);
    chk("alu_fn_aluen", 32'(ALU_EN),  32'h1);
    chk("alu_fn_fun",   32'(ALU_FUN), 32'h3);
    chk("alu_fn_clken", 32'(CLK_EN),  32'h1);
    chk("alu_fn_wren",  32'(WrEn),    32'h0);
    idle(1);
    chk("alu_after_clken", 32'(CLK_EN),  32'h0);
    chk("alu_after_aluen", 32'(ALU_EN),  32'h0);
    chk("alu_fun_holds",   32'(ALU_FUN), 32'h3);

    // Unknown command then recovery via no-operand ALU frame
    pulse(8'h55);
    chk("unk_cmderr", 32'(CMD_ERR), 32'h1);
    chk("unk_clken",  32'(CLK_EN),  32'h0);
    pulse(8'hDD);
    chk("nop_cmderr_clear", 32'(CMD_ERR), 32'h0);
    chk("nop_clken",        32'(CLK_EN),  32'h1);
    pulse(8'h02);
    chk("nop_aluen",       32'(ALU_EN),  32'h1);
    chk("nop_fun",         32'(ALU_FUN), 32'h2);
    chk("nop_wren",        32'(WrEn),    32'h0);
    chk("nop_rden",        32'(RdEn),    32'h0);
    chk("nop_addr_holds",  32'(Address), 32'h1);
    chk("nop_data_holds",  32'(WrData),  32'h20);
    idle(2);

    // Timeout: CMD_ERR exactly 20 cycles after the last byte
    pulse(8'hAA);
    pulse(8'h05);
    cnt_err = 0;
    cnt_wr  = 0;
    for (int i = 1; i < 20; i++) begin
      idle(1);
      if (CMD_ERR) cnt_err++;
      if (WrEn)    cnt_wr++;
    end
    chk("tmo_no_early_err", 32'(cnt_err), 32'h0);
    idle(1);
    chk("tmo_cmderr", 32'(CMD_ERR), 32'h1);
    chk("tmo_no_wren", 32'(cnt_wr + int'(WrEn)), 32'h0);
    idle(1);
    chk("tmo_cmderr_one_cycle", 32'(CMD_ERR), 32'h0);
    pulse(8'h3C);
    chk("tmo_then_unk_cmderr", 32'(CMD_ERR), 32'h1);
    chk("tmo_then_unk_wren",   32'(WrEn),    32'h0);
    idle(2);

    // Byte arriving on the expiry cycle wins
    pulse(8'hAA);
    idle(19);
    chk("edge_no_err_yet", 32'(CMD_ERR), 32'h0);
    pulse(8'h06);
    chk("edge_byte_wins_noerr", 32'(CMD_ERR), 32'h0);
    pulse(8'h5A);
    chk("edge_wren", 32'(WrEn),    32'h1);
    chk("edge_addr", 32'(Address), 32'h6);
    chk("edge_data", 32'(WrData),  32'h5A);
    idle(2);

    // Reset mid-frame
    pulse(8'hCC);
    pulse(8'h10);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    chk_all_zero("midrst");
    pulse(8'hBB);
    chk("midrst_bb_aluen", 32'(ALU_EN), 32'h0);
    pulse(8'h02);
    chk("midrst_rden",  32'(RdEn),    32'h1);
    chk("midrst_addr",  32'(Address), 32'h2);
    chk("midrst_aluen", 32'(ALU_EN),  32'h0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
